// File: rtl/rv_branch_predictor.sv
// ---------------------------------------------------------------------------
// rv_branch_predictor
//   Dynamic branch predictor for the five-stage RISC-V pipeline.
//   The IF stage looks up the fetch PC every cycle and gets a prediction and
//   a next-PC target with zero latency. Resolved branches/jumps from ID train
//   the table. Three modes: static not-taken (0), bimodal (1), gshare (2).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous flush: entries, history and statistics
//   lk_pc             fetch PC to predict
//   pred_taken        prediction for lk_pc (combinational)
//   pred_target       predicted next PC (combinational)
//   pred_ghr          global history, carried down the pipe with the instr
//   upd_*             training interface from the resolving stage
//   upd_mispredict    combinational mispredict flag for the update
//   stat_branches     saturating count of resolved control-flow instructions
//   stat_mispred      saturating count of mispredictions
// ---------------------------------------------------------------------------
module rv_branch_predictor #(
    parameter int ENTRIES   = 32,
    parameter int CNT_W     = 2,
    parameter int PRED_MODE = 1,
    parameter int HIST_W    = 5,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [31:0]       lk_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_WT  = CNT_W'(1) << (CNT_W - 1);  // weakly taken
    localparam logic [CNT_W-1:0]  CNT_WNT = CNT_WT - CNT_W'(1);         // weakly not-taken
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Table state; kept in flops because every entry needs an async reset.
    logic              valid_reg  [ENTRIES];
    logic [TAG_W-1:0]  tag_reg    [ENTRIES];
    logic [31:0]       target_reg [ENTRIES];
    logic [CNT_W-1:0]  cnt_reg    [ENTRIES];

    logic [HIST_W-1:0] ghr_reg;
    logic [STAT_W-1:0] stat_branches_reg;
    logic [STAT_W-1:0] stat_mispred_reg;

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              lk_hit;
    logic              upd_hit;
    logic              train;

    // Low PC bits are always zero for word-aligned fetch.
    logic unused_ok;
    assign unused_ok = ^{lk_pc[1:0], upd_pc[1:0], upd_ghr};

    // Index: PC word bits, optionally XORed with zero-extended history.
    always_comb begin
        lk_idx  = lk_pc[IDX_W+1:2];
        upd_idx = upd_pc[IDX_W+1:2];
        if (PRED_MODE == 2) begin
            lk_idx  = lk_pc[IDX_W+1:2]  ^ IDX_W'(ghr_reg);
            upd_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
        end
    end

    assign lk_hit  = valid_reg[lk_idx]  && (tag_reg[lk_idx]  == lk_pc[31:IDX_W+2]);
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_pc[31:IDX_W+2]);

    assign pred_taken  = (PRED_MODE != 0) && lk_hit && cnt_reg[lk_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_reg[lk_idx] : lk_pc + 32'd4;
    assign pred_ghr    = ghr_reg;

    // Target mismatch only matters when the branch was actually taken.
    assign upd_mispredict = upd_valid &&
                            ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));

    // clear wins over a same-cycle update; mode 0 never trains.
    assign train = upd_valid && !clear && (PRED_MODE != 0);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= '0;
                    cnt_reg[gi]    <= CNT_WNT;
                end else if (clear) begin
                    valid_reg[gi]  <= 1'b0;
                    cnt_reg[gi]    <= CNT_WNT;
                end else if (train && (upd_idx == IDX_W'(gi))) begin
                    if (upd_taken) begin
                        if (upd_hit) begin
                            target_reg[gi] <= upd_target;
                            if (cnt_reg[gi] != CNT_MAX) begin
                                cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                            end
                        end else begin
                            // Allocate (or steal an aliased entry).
                            valid_reg[gi]  <= 1'b1;
                            tag_reg[gi]    <= upd_pc[31:IDX_W+2];
                            target_reg[gi] <= upd_target;
                            cnt_reg[gi]    <= CNT_WT;
                        end
                    end else if (upd_hit && (cnt_reg[gi] != '0)) begin
                        cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Non-speculative global history: shifted only by resolved outcomes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg <= '0;
        end else if (clear) begin
            ghr_reg <= '0;
        end else if (upd_valid && (PRED_MODE == 2)) begin
            ghr_reg <= (ghr_reg << 1) | HIST_W'(upd_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_reg <= '0;
            stat_mispred_reg  <= '0;
        end else if (clear) begin
            stat_branches_reg <= '0;
            stat_mispred_reg  <= '0;
        end else begin
            if (upd_valid && (stat_branches_reg != STAT_MAX)) begin
                stat_branches_reg <= stat_branches_reg + STAT_W'(1);
            end
            if (upd_mispredict && (stat_mispred_reg != STAT_MAX)) begin
                stat_mispred_reg <= stat_mispred_reg + STAT_W'(1);
            end
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_mispred  = stat_mispred_reg;

endmodule

// File: tb/tb_rv_branch_predictor.sv
module tb_rv_branch_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Bimodal instance, 16 entries.
    logic        clear = 1'b0;
    logic [31:0] lk_pc = 32'h40;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [4:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [4:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        upd_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    rv_branch_predictor #(
        .ENTRIES(16), .CNT_W(2), .PRED_MODE(1), .HIST_W(5), .STAT_W(32)
    ) u_bimodal (
        .clk(clk), .rst_n(rst_n), .clear(clear), .lk_pc(lk_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    // Gshare instance, 16 entries, 4-bit history, 2-bit stats (saturation).
    logic        m2_clear = 1'b0;
    logic [31:0] m2_lk_pc = 32'h40;
    logic        m2_pred_taken;
    logic [31:0] m2_pred_target;
    logic [3:0]  m2_pred_ghr;
    logic        m2_upd_valid = 1'b0;
    logic [31:0] m2_upd_pc = '0;
    logic [3:0]  m2_upd_ghr = '0;
    logic        m2_upd_taken = 1'b0;
    logic [31:0] m2_upd_target = '0;
    logic        m2_upd_pred_taken = 1'b0;
    logic [31:0] m2_upd_pred_target = '0;
    logic        m2_upd_mispredict;
    logic [1:0]  m2_stat_branches;
    logic [1:0]  m2_stat_mispred;

    rv_branch_predictor #(
        .ENTRIES(16), .CNT_W(2), .PRED_MODE(2), .HIST_W(4), .STAT_W(2)
    ) u_gshare (
        .clk(clk), .rst_n(rst_n), .clear(m2_clear), .lk_pc(m2_lk_pc),
        .pred_taken(m2_pred_taken), .pred_target(m2_pred_target), .pred_ghr(m2_pred_ghr),
        .upd_valid(m2_upd_valid), .upd_pc(m2_upd_pc), .upd_ghr(m2_upd_ghr),
        .upd_taken(m2_upd_taken), .upd_target(m2_upd_target),
        .upd_pred_taken(m2_upd_pred_taken), .upd_pred_target(m2_upd_pred_target),
        .upd_mispredict(m2_upd_mispredict),
        .stat_branches(m2_stat_branches), .stat_mispred(m2_stat_mispred)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic [31:0] lk;
        logic        e_misp;
        logic        e_pt;
        logic [31:0] e_ptgt;
        int          e_br;   // stats seen before this vector's edge
        int          e_mp;
    } vec_t;

    vec_t vecs[14];

    task automatic m2_update(input logic [31:0] pc, input logic [3:0] ghr, input logic tk,
                             input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                             input logic e_misp);
        m2_upd_valid = 1'b1; m2_upd_pc = pc; m2_upd_ghr = ghr; m2_upd_taken = tk;
        m2_upd_target = tgt; m2_upd_pred_taken = ptk; m2_upd_pred_target = ptgt;
        #2;
        check("m2_upd_mispredict", 32'(m2_upd_mispredict), 32'(e_misp));
        tick();
        m2_upd_valid = 1'b0;
    endtask

    initial begin
        // Expected values for the bimodal sequence at index 0 (0x40 / alias 0x440).
        //           uv upc       ut utgt      upt uptgt     lk        misp pt ptgt      br mp
        vecs[0]  = '{1, 32'h40,  1, 32'h100, 0, 32'h44,  32'h40,  1,   0, 32'h44,  0, 0};
        vecs[1]  = '{1, 32'h40,  1, 32'h100, 1, 32'h100, 32'h40,  0,   1, 32'h100, 1, 1};
        vecs[2]  = '{1, 32'h40,  1, 32'h100, 1, 32'h100, 32'h40,  0,   1, 32'h100, 2, 1};
        vecs[3]  = '{1, 32'h40,  1, 32'h100, 1, 32'h100, 32'h40,  0,   1, 32'h100, 3, 1};
        vecs[4]  = '{1, 32'h40,  0, 32'h0,   1, 32'h100, 32'h40,  1,   1, 32'h100, 4, 1};
        vecs[5]  = '{1, 32'h40,  0, 32'h0,   1, 32'h100, 32'h40,  1,   1, 32'h100, 5, 2};
        vecs[6]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40,  0,   0, 32'h44,  6, 3};
        vecs[7]  = '{1, 32'h40,  1, 32'h180, 1, 32'h100, 32'h40,  1,   0, 32'h44,  6, 3};
        vecs[8]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40,  0,   1, 32'h180, 7, 4};
        vecs[9]  = '{1, 32'h80,  0, 32'h0,   0, 32'h999, 32'h40,  0,   1, 32'h180, 7, 4};
        vecs[10] = '{1, 32'h440, 1, 32'h500, 0, 32'h444, 32'h40,  1,   1, 32'h180, 8, 4};
        vecs[11] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40,  0,   0, 32'h44,  9, 5};
        vecs[12] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h440, 0,   1, 32'h500, 9, 5};
        vecs[13] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h44,  0,   0, 32'h48,  9, 5};

        // Reset state, held while rst_n is low.
        #12;
        check("rst pred_taken",    32'(pred_taken), 32'd0);
        check("rst pred_target",   pred_target, 32'h44);
        check("rst stat_branches", stat_branches, 32'd0);
        check("rst stat_mispred",  stat_mispred, 32'd0);
        check("rst pred_ghr",      32'(pred_ghr), 32'd0);
        check("rst m2 pred_ghr",   32'(m2_pred_ghr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Bimodal table: training, saturation, target update, aliasing.
        for (int i = 0; i < 14; i++) begin
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            upd_target = vecs[i].utgt; upd_pred_taken = vecs[i].upt;
            upd_pred_target = vecs[i].uptgt; lk_pc = vecs[i].lk;
            #2;
            $display("vec %0d: lk=0x%0h upd_valid=%0b upd_pc=0x%0h", i, lk_pc, upd_valid, upd_pc);
            check($sformatf("v%0d upd_mispredict", i), 32'(upd_mispredict), 32'(vecs[i].e_misp));
            check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
            check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            check($sformatf("v%0d stat_branches", i), stat_branches, 32'(vecs[i].e_br));
            check($sformatf("v%0d stat_mispred", i), stat_mispred, 32'(vecs[i].e_mp));
            tick();
        end
        upd_valid = 1'b0;
        check("bimodal pred_ghr held", 32'(pred_ghr), 32'd0);

        // Same-cycle lookup/update: lookup sees pre-update contents.
        lk_pc = 32'h440;
        upd_valid = 1'b1; upd_pc = 32'h440; upd_taken = 1'b0; upd_target = 32'h0;
        upd_pred_taken = 1'b1; upd_pred_target = 32'h500;
        #2;
        check("same-cycle pred_taken",  32'(pred_taken), 32'd1);
        check("same-cycle pred_target", pred_target, 32'h500);
        check("same-cycle mispredict",  32'(upd_mispredict), 32'd1);
        tick();
        upd_valid = 1'b0;
        #2;
        check("after-upd pred_taken",  32'(pred_taken), 32'd0);
        check("after-upd pred_target", pred_target, 32'h444);
        check("after-upd branches",    stat_branches, 32'd10);
        check("after-upd mispred",     stat_mispred, 32'd6);

        // clear together with upd_valid: the update is dropped.
        clear = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h440; upd_taken = 1'b1; upd_target = 32'h600;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h444;
        #2;
        check("clear-cycle mispredict", 32'(upd_mispredict), 32'd1);
        tick();
        clear = 1'b0; upd_valid = 1'b0;
        #2;
        check("post-clear branches",    stat_branches, 32'd0);
        check("post-clear mispred",     stat_mispred, 32'd0);
        check("post-clear 0x440 taken", 32'(pred_taken), 32'd0);
        check("post-clear 0x440 tgt",   pred_target, 32'h444);
        lk_pc = 32'h40;
        #1;
        check("post-clear 0x40 taken",  32'(pred_taken), 32'd0);
        check("post-clear 0x40 tgt",    pred_target, 32'h44);

        // Next update trains normally.
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
        tick();
        upd_valid = 1'b0;
        #2;
        check("retrain pred_taken",  32'(pred_taken), 32'd1);
        check("retrain pred_target", pred_target, 32'h100);
        check("retrain branches",    stat_branches, 32'd1);

        // Gshare: history taken,taken,not-taken -> 4'b0110.
        m2_update(32'h58,   4'h0, 1'b1, 32'h300,  1'b0, 32'h5c,   1'b1);
        check("m2 ghr after T", 32'(m2_pred_ghr), 32'h1);
        m2_update(32'h1000, 4'h1, 1'b1, 32'h2000, 1'b0, 32'h1004, 1'b1);
        check("m2 ghr after TT", 32'(m2_pred_ghr), 32'h3);
        m2_update(32'h1000, 4'h3, 1'b0, 32'h0,    1'b0, 32'h1004, 1'b0);
        check("m2 ghr after TTN", 32'(m2_pred_ghr), 32'h6);
        m2_lk_pc = 32'h40;    // index 0 ^ 6 = 6, trained via 0x58 with ghr 0
        #2;
        check("m2 0x40 pred_taken",  32'(m2_pred_taken), 32'd1);
        check("m2 0x40 pred_target", m2_pred_target, 32'h300);
        m2_lk_pc = 32'h58;    // index 6 ^ 6 = 0, empty
        #1;
        check("m2 0x58 pred_taken",  32'(m2_pred_taken), 32'd0);
        check("m2 0x58 pred_target", m2_pred_target, 32'h5c);
        m2_update(32'h40,   4'h6, 1'b1, 32'h300,  1'b1, 32'h300,  1'b0);
        m2_update(32'h2000, 4'h0, 1'b0, 32'h0,    1'b1, 32'h10,   1'b1);
        m2_update(32'h2000, 4'h0, 1'b1, 32'h10,   1'b0, 32'h2004, 1'b1);
        check("m2 stat_branches sat", 32'(m2_stat_branches), 32'd3);
        check("m2 stat_mispred sat",  32'(m2_stat_mispred), 32'd3);

        // Asynchronous reset mid-stream with an update pending.
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst pred_taken",  32'(pred_taken), 32'd0);
        check("async rst pred_target", pred_target, 32'h44);
        check("async rst branches",    stat_branches, 32'd0);
        upd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
